// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down modulo counter with built-in prescaler.
// Digits always hold valid BCD below MOD; loads are range-checked before being accepted.
module bcd_mod_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int MOD      = 60,
    parameter int PW       = 26
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tick,
    output logic       tc,
    output logic       load_err
);

    localparam logic [3:0]    MAX_ONES = 4'((MOD - 1) % 10);
    localparam logic [3:0]    MAX_TENS = 4'((MOD - 1) / 10);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d;
    logic          tick_q, tick_d, tc_q, tc_d, load_err_q, load_err_d;

    logic          step;
    logic          at_max, at_zero, load_ok;
    logic [7:0]    load_val;

    assign step    = en && (pre_q == PRE_LAST);
    assign at_max  = (ones_q == MAX_ONES) && (tens_q == MAX_TENS);
    assign at_zero = (ones_q == 4'd0) && (tens_q == 4'd0);

    // Worst case 15*10+15 = 165 still fits in 8 bits, so the range test is exact.
    assign load_val = 8'(load_tens) * 8'd10 + 8'(load_ones);
    assign load_ok  = (load_ones <= 4'd9) && (load_tens <= 4'd9) && (load_val < 8'(MOD));

    always_comb begin
        pre_d      = pre_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        tick_d     = 1'b0;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            // Load always wins, even over a pending step on the same edge.
            pre_d = '0;
            if (load_ok) begin
                ones_d = load_ones;
                tens_d = load_tens;
            end else begin
                ones_d     = 4'd0;
                tens_d     = 4'd0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            pre_d = step ? '0 : pre_q + 1'b1;
            if (step) begin
                tick_d = 1'b1;
                if (up) begin
                    if (at_max) begin
                        ones_d = 4'd0;
                        tens_d = 4'd0;
                        tc_d   = 1'b1;
                    end else if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    if (at_zero) begin
                        ones_d = MAX_ONES;
                        tens_d = MAX_TENS;
                        tc_d   = 1'b1;
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q      <= '0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            tick_q     <= 1'b0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            tick_q     <= tick_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign tick     = tick_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter with TICK_DIV=4, MOD=60.
// Observed state is packed as {tens, ones, tick, tc, load_err}.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en, up, load;
    logic [3:0] load_ones, load_tens;
    logic [3:0] ones, tens;
    logic       tick, tc, load_err;

    int n_chk = 0;
    int n_err = 0;

    bcd_mod_counter #(.TICK_DIV(4), .MOD(60), .PW(3)) dut (
        .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
        .load_ones(load_ones), .load_tens(load_tens),
        .ones(ones), .tens(tens), .tick(tick), .tc(tc), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] st(input int t, input int o, input bit tk, input bit c, input bit e);
        return {4'(t), 4'(o), tk, c, e};
    endfunction

    function automatic logic [10:0] obs();
        return {tens, ones, tick, tc, load_err};
    endfunction

    task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got t=%0d o=%0d tick=%b tc=%b err=%b, want t=%0d o=%0d tick=%b tc=%b err=%b",
                     tag, act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // n-1 quiet edges (digits held, no tick) then the step edge.
    task automatic steps(input string tag, input int pt, input int po, input int t, input int o, input bit c);
        for (int i = 0; i < 3; i++) clk1();
        chk({tag, "_pre"}, obs(), st(pt, po, 0, 0, 0));
        clk1();
        chk(tag, obs(), st(t, o, 1, c, 0));
    endtask

    task automatic do_load(input int t, input int o);
        load = 1'b1; load_tens = 4'(t); load_ones = 4'(o);
        clk1();
        load = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0;
        load_ones = 4'd0; load_tens = 4'd0;
        clk1();
        chk("reset", obs(), st(0, 0, 0, 0, 0));
        resetn = 1'b1;

        // free-run count up: tick after every 4th edge
        for (int i = 1; i <= 12; i++) begin
            clk1();
            chk($sformatf("run%0d", i), obs(), st(0, i / 4, (i % 4) == 0, 0, 0));
        end

        // wrap up through 59
        do_load(5, 8);
        chk("ld58", obs(), st(5, 8, 0, 0, 0));
        steps("up59", 5, 8, 5, 9, 0);
        steps("wrap00", 5, 9, 0, 0, 1);
        steps("up01", 0, 0, 0, 1, 0);

        // down wrap from 00 and borrow
        resetn = 1'b0; clk1(); resetn = 1'b1; up = 1'b0;
        steps("dnwrap", 0, 0, 5, 9, 1);
        do_load(1, 0);
        chk("ld10", obs(), st(1, 0, 0, 0, 0));
        steps("borrow", 1, 0, 0, 9, 0);

        // invalid and disabled loads
        do_load(6, 0);
        chk("bad60", obs(), st(0, 0, 0, 0, 1));
        do_load(3, 3);
        chk("ld33", obs(), st(3, 3, 0, 0, 0));
        do_load(0, 12);
        chk("bad012", obs(), st(0, 0, 0, 0, 1));
        clk1();
        chk("errclr", obs(), st(0, 0, 0, 0, 0));
        en = 1'b0;
        do_load(4, 2);
        chk("ld42off", obs(), st(4, 2, 0, 0, 0));

        // pause mid-prescale: no lost or extra counts
        up = 1'b1; en = 1'b1;
        clk1(); clk1();
        en = 1'b0;
        for (int i = 0; i < 10; i++) clk1();
        chk("paused", obs(), st(4, 2, 0, 0, 0));
        en = 1'b1;
        clk1();
        chk("resume1", obs(), st(4, 2, 0, 0, 0));
        clk1();
        chk("resume2", obs(), st(4, 3, 1, 0, 0));

        // load during the prescaler terminal cycle discards the step
        clk1(); clk1(); clk1();
        do_load(1, 5);
        chk("ldterm", obs(), st(1, 5, 0, 0, 0));
        steps("after15", 1, 5, 1, 6, 0);

        // asynchronous reset between edges
        do_load(3, 7);
        clk1(); clk1();
        #2 resetn = 1'b0;
        #1 chk("async", obs(), st(0, 0, 0, 0, 0));
        #1 resetn = 1'b1;
        steps("rst_run", 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Two-digit BCD up/down modulo counter with a built-in prescaler.
- Produces `ones` and `tens` BCD digits. Each digit feeds one BCD-to-7-segment decoder instance, which drives HEX0 and HEX1.
- Typical uses: seconds/minutes counters (MOD=60), lap counters (MOD=100), countdown timers.
- Digits are always valid BCD (0–9), so the downstream decoder's blank codes (10–15) never appear during normal operation.

Parameters:
- `TICK_DIV`, default 50000000: clock cycles per count step (1 Hz at 50 MHz). Legal range ≥2.
- `MOD`, default 60: count modulus. Value runs 0..MOD-1. Legal range 2..100.
- `PW`, default 26: prescaler width. Must satisfy 2^PW ≥ TICK_DIV.

Ports:
- `clk`  in  1  system clock, rising edge
- `resetn`  in  1  asynchronous active-low reset
- `en`  in  1  count enable; prescaler and digits hold when 0
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `load`  in  1  synchronous load strobe, level-sampled
- `load_ones`  in  4  BCD ones digit to load
- `load_tens`  in  4  BCD tens digit to load
- `ones`  out  4  BCD ones digit, registered
- `tens`  out  4  BCD tens digit, registered
- `tick`  out  1  one-cycle pulse, high in the cycle after a count step
- `tc`  out  1  one-cycle pulse, high in the cycle after a wrap (terminal count)
- `load_err`  out  1  one-cycle pulse, high in the cycle after a rejected load

Behaviour:
- Reset (`resetn`=0, asynchronous, any time): `ones`=0, `tens`=0, prescaler=0, `tick`=0, `tc`=0, `load_err`=0. All state is held until the first rising edge after `resetn` returns to 1.
- Priority at each rising edge: `load` > step > hold.
- Prescaler:
  - When `en`=1 and `load`=0: prescaler increments each cycle. It wraps from TICK_DIV-1 to 0, and a step occurs on that same edge.
  - When `en`=0: prescaler holds.
  - Consecutive steps are exactly TICK_DIV cycles apart while `en` stays high.
- Step up (`up`=1):
  - Value = MOD-1 → digits become 00 and `tc` pulses.
  - Otherwise, `ones`=9 → `ones`=0 and `tens`+1.
  - Otherwise, `ones`+1.
- Step down (`up`=0):
  - Value = 00 → digits become MOD-1 in BCD (e.g. 5,9 for MOD=60; 9,9 for MOD=100) and `tc` pulses.
  - Otherwise, `ones`=0 → `ones`=9 and `tens`-1.
  - Otherwise, `ones`-1.
- `tick`: registered, high for exactly one cycle following each step edge, coincident with the new digit values. `tc` is high in the same cycle when the step wrapped.
- `up` is sampled only at step edges. Changing direction between steps is legal and takes effect at the next step.
- Load (`load`=1 on an edge, regardless of `en`):
  - Valid load (`load_ones` ≤ 9, `load_tens` ≤ 9, and 10·`load_tens` + `load_ones` < MOD): digits take the load values.
  - Invalid load: digits are cleared to 00 and `load_err` pulses the next cycle.
  - In both cases the prescaler clears to 0, and no step, `tick` or `tc` occurs on that edge.
  - A load held high for N cycles reloads every cycle and blocks stepping.
- A load coinciding with a prescaler terminal cycle: the load wins and the step is discarded.
- Output invariant: digits always form valid BCD below MOD, from reset onward. No illegal intermediate value is ever visible.
- Latency:
  - `load` → digits: 1 cycle.
  - `en` rising → first step: TICK_DIV cycles, when the prescaler starts at 0.
- `tick`, `tc` and `load_err` are never high for two consecutive cycles when TICK_DIV ≥ 2. Exception: `load_err` can repeat on back-to-back invalid loads.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, MOD=60.
- Reset release, `en`=1, `up`=1, 12 cycles → digits 0,0 → 0,1 → 0,2 → 0,3. `tick` high in cycles 5, 9, 13 after release; `tc` stays 0.
- Load 5,8 then count up → 5,9 then 0,0 with `tc`=1 and `tick`=1 in the same cycle. The next step gives 0,1 with `tc`=0.
- Reset, then `up`=0 with one step → 5,9 with `tc`=1. Load 1,0 then step down → 0,9 (ones borrow, tens decrement).
- Invalid loads:
  - `load_tens`=6, `load_ones`=0 → digits 0,0 and `load_err`=1 for one cycle.
  - `load_ones`=12 → same result.
  - Load 4,2 while `en`=0 → digits show 4,2 next cycle and no `tick`.
- `en` dropped for 10 cycles mid-prescale, then raised → the step arrives after the remaining prescaler cycles, with no lost or extra counts. `load` asserted in a prescaler terminal cycle → loaded value appears and no `tick`.
- `resetn` pulsed low asynchronously between clock edges while digits are 3,7 → outputs go to 0,0 and 0 immediately, before the next clock edge. Counting resumes from 0,0 after release, with the first `tick` 4 cycles later.
